axi_burst_mem_slave: RTL and testbench
======================================

# axi_burst_mem_slave

Parametrised AXI-style burst memory slave with independent read (AR/R) and write (AW/W/B) channels sharing one 1R1W storage array. It generalises the team's 8-bit/256-entry slave to configurable data, address, ID and length widths, adds per-beat error responses and proper valid/ready handshakes on every channel, and runs reads and writes concurrently. It sits behind the interconnect as a leaf target.

## Interface
- DATA_W, 8, data beat width
- ADDR_W, 8, word address width
- DEPTH, 256, implemented words (≤ 2^ADDR_W); addresses ≥ DEPTH are out of range
- ID_W, 4, transaction ID width
- LEN_W, 4, burst length field; beats = len+1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- arvalid/arready  in/out  1  read address handshake
- arid, araddr, arlen  in  ID_W, ADDR_W, LEN_W  read request
- rvalid/rready  out/in  1  read data handshake
- rid, rdata, rresp, rlast  out  ID_W, DATA_W, 2, 1  read beat
- awvalid/awready  in/out  1  write address handshake
- awid, awaddr, awlen  in  ID_W, ADDR_W, LEN_W  write request
- wvalid/wready  in/out  1  write data handshake
- wdata, wlast  in  DATA_W, 1  write beat
- bvalid/bready  out/in  1  write response handshake
- bid, bresp  out  ID_W, 2  write response

## Operation
- Burst type INCR only; beat k address = base + k, computed in ADDR_W+1 bits; no wrap at 2^ADDR_W, overflow counts as out of range.
- Responses: OKAY=2'b00, SLVERR=2'b10.
- Read FSM: R_IDLE → (arvalid&&arready) → R_DATA → (rvalid&&rready&&rlast) → R_IDLE. arready = (state==R_IDLE). In R_DATA rvalid=1; rid = latched arid; rlast=1 on beat arlen.
- Read beat in range: rdata = mem[addr], rresp OKAY. Out of range: rdata = 0, rresp SLVERR; burst continues to completion.
- rdata/rresp/rlast held stable while rvalid && !rready.
- Write FSM: W_IDLE → (awvalid&&awready) → W_DATA → (final beat accepted) → W_RESP → (bvalid&&bready) → W_IDLE. awready = W_IDLE, wready = W_DATA, bvalid = W_RESP.
- Each accepted in-range beat writes mem[addr] <= wdata; out-of-range beats discarded, sticky error flag set.
- Burst ends after exactly awlen+1 accepted beats regardless of wlast; wlast not coincident with final beat (early or missing) sets error flag.
- bresp = SLVERR if error flag set, else OKAY; bid = latched awid; error flag clears on W_IDLE entry.
- Same-cycle read and write to one address: read returns old data (read-before-write).

## Timing
- Reset values: arready=1, awready=1, rvalid=0, rlast=0, rdata=0, rresp=0, rid=0, wready=0, bvalid=0, bresp=0, bid=0; both FSMs idle, beat counters 0. Memory contents not reset.
- Reset mid-burst: burst abandoned immediately; no B response generated; writes already accepted remain in memory.
- AR handshake in cycle T → first rvalid in T+1; one beat per cycle with rready held high; zero bubbles.
- After the last R handshake in cycle T, arready=1 in T+1. Minimum AR-to-AR spacing: beats+1 cycles.
- AW handshake in T → wready in T+1; final W handshake in T' → bvalid in T'+1; B handshake in T'' → awready in T''+1.
- Read and write channels fully independent; no cross-channel stalls.

## Structure
- Package axi_mem_pkg: resp encodings (RESP_OKAY, RESP_SLVERR), read/write state enums.
- Sub-module mem_1r1w (parameters DATA_W, DEPTH): flop array, combinational read port, synchronous write port; top instantiates one.
- Top holds both FSMs, beat counters, latched IDs/addresses and the error flag.

## Test plan
- Write burst awaddr=0x10, awlen=3, wdata 0xA1..0xA4, wlast on beat 3 → bresp OKAY, bid=awid; read araddr=0x10, arlen=3 → 0xA1..0xA4, rlast only on 4th beat, all OKAY.
- DEPTH=200, read araddr=198, arlen=3 → beats 0/1 real data OKAY, beats 2/3 rdata=0 SLVERR; write of same range → bresp SLVERR, mem[198..199] updated only.
- awlen=2 with wlast asserted on beat 1 → all 3 beats still accepted, bresp SLVERR.
- rready toggled 1,0,0,1 during 4-beat read → rdata/rlast stable while stalled, no beat lost or duplicated.
- Concurrent 8-beat read and 8-beat write to overlapping addresses → read returns pre-write data where the same cycle collides; both channels complete with no added latency.
- rst asserted mid write burst (beat 2 of 4) → all outputs at reset values next edge, bvalid never asserted, beats 0–1 present in memory.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared encodings for the burst memory slave: response codes and the
// read/write channel state values.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

endpackage

// File: rtl/axi_burst_mem_slave_mem_1r1w.sv
// Flop-array storage: combinational read port, synchronous write port.
// Contents are deliberately not reset.
module mem_1r1w #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Guard the read so a non-power-of-two depth never indexes past the array.
  assign rdata = ({1'b0, raddr} < DEPTH_V) ? mem_q[raddr] : '0;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI-style INCR burst memory slave with independent read and write channels
// sharing one 1R1W array; out-of-range beats answer SLVERR.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read request
// R_DATA | presenting read beats, rvalid high
// W_IDLE | awready high, waiting for a write request
// W_DATA | accepting write beats, wready high
// W_RESP | presenting the write response, bvalid high
module axi_burst_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp
);

  localparam int MA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic              r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] r_base_q, r_base_d;
  logic [LEN_W-1:0]  r_len_q, r_len_d;
  logic [LEN_W-1:0]  r_beat_q, r_beat_d;
  logic [LEN_W-1:0]  r_next_beat;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic [ADDR_W:0]   rd_addr_ext;
  logic              rd_in_range;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rd_beat_data;
  logic [1:0]        rd_beat_resp;

  logic [1:0]        w_state_q, w_state_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [LEN_W-1:0]  w_len_q, w_len_d;
  logic [LEN_W-1:0]  w_beat_q, w_beat_d;
  logic              w_err_q, w_err_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ADDR_W:0]   wr_addr_ext;
  logic              wr_in_range;
  logic              w_final;
  logic              mem_we;

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

  assign awready = (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = bid_q;
  assign bresp   = bresp_q;

  // The read port looks one beat ahead so each beat is registered the cycle
  // before it is presented; sampling before the write edge gives old data.
  always_comb begin
    r_next_beat = r_beat_q + LEN_W'(1);
    if (r_state_q == R_IDLE) begin
      rd_addr_ext = {1'b0, araddr};
    end else begin
      rd_addr_ext = {1'b0, r_base_q} + (ADDR_W + 1)'(r_next_beat);
    end
    rd_in_range  = (rd_addr_ext < DEPTH_X);
    rd_beat_data = rd_in_range ? mem_rdata : '0;
    rd_beat_resp = rd_in_range ? RESP_OKAY : RESP_SLVERR;
  end

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    r_base_d  = r_base_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    if (r_state_q == R_IDLE) begin
      if (arvalid) begin
        r_state_d = R_DATA;
        rid_d     = arid;
        r_base_d  = araddr;
        r_len_d   = arlen;
        r_beat_d  = '0;
        rdata_d   = rd_beat_data;
        rresp_d   = rd_beat_resp;
        rlast_d   = (arlen == '0);
      end
    end else if (rready) begin
      if (rlast_q) begin
        r_state_d = R_IDLE;
        rlast_d   = 1'b0;
      end else begin
        r_beat_d = r_next_beat;
        rdata_d  = rd_beat_data;
        rresp_d  = rd_beat_resp;
        rlast_d  = (r_next_beat == r_len_q);
      end
    end
  end

  always_comb begin
    wr_addr_ext = {1'b0, w_base_q} + (ADDR_W + 1)'(w_beat_q);
    wr_in_range = (wr_addr_ext < DEPTH_X);
    w_final     = (w_beat_q == w_len_q);
    mem_we      = (w_state_q == W_DATA) && wvalid && wr_in_range;
  end

  // The burst length comes from awlen alone; wlast is only checked.
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    w_base_d  = w_base_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_err_d   = w_err_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          w_state_d = W_DATA;
          bid_d     = awid;
          w_base_d  = awaddr;
          w_len_d   = awlen;
          w_beat_d  = '0;
          w_err_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          if (!wr_in_range || (wlast != w_final)) begin
            w_err_d = 1'b1;
          end
          if (w_final) begin
            w_state_d = W_RESP;
            bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
          end else begin
            w_beat_d = w_beat_q + LEN_W'(1);
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          w_err_d   = 1'b0;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        w_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      r_base_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      w_base_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      r_base_q  <= r_base_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      w_base_q  <= w_base_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_err_q   <= w_err_d;
      bresp_q   <= bresp_d;
    end
  end

  mem_1r1w #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .raddr(rd_addr_ext[MA_W-1:0]),
    .rdata(mem_rdata),
    .we   (mem_we),
    .waddr(wr_addr_ext[MA_W-1:0]),
    .wdata(wdata)
  );

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomized and directed bench for axi_burst_mem_slave with a queue-based
// scoreboard fed by an array model of the memory.
module tb_axi_burst_mem_slave;
  import axi_mem_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;

  logic clk = 1'b0;
  logic rst;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [ID_W-1:0] arid, rid, awid, bid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [LEN_W-1:0] arlen, awlen;
  logic [DATA_W-1:0] rdata, wdata;
  logic [1:0] rresp, bresp;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;

  always #5 clk = ~clk;

  axi_burst_mem_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ID_W(ID_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } rbeat_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } bexp_t;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_r_cyc = 0;
  rbeat_t rq[$];
  bexp_t bq[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] wdat [16];
  bit rr_rand = 0;
  bit br_rand = 0;
  bit rr_pat[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out, required handshake within bound (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ready drivers: optional fixed pattern, otherwise random or held high.
  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rr_pat.size() > 0) rready = rr_pat.pop_front();
      else rready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bready = br_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Read-channel monitor.
  bit r_stall = 0;
  bit chk_ar_next = 0;
  rbeat_t r_held;
  rbeat_t r_exp;
  always @(negedge clk) begin
    if (rst) begin
      r_stall = 0;
      chk_ar_next = 0;
    end else begin
      if (chk_ar_next) begin
        chk("arready_after_rlast", arready, 1);
        chk_ar_next = 0;
      end
      if (rvalid) begin
        if (r_stall) begin
          chk("rdata_stable", rdata, r_held.data);
          chk("rresp_stable", rresp, r_held.resp);
          chk("rlast_stable", rlast, r_held.last);
        end
        if (!rready) begin
          r_stall = 1;
          r_held.data = rdata;
          r_held.resp = rresp;
          r_held.last = rlast;
        end else begin
          r_stall = 0;
          if (rq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL r_unexpected: beat 0x%0h accepted, required no outstanding beat", rdata);
          end else begin
            r_exp = rq.pop_front();
            chk("rid", rid, r_exp.id);
            chk("rdata", rdata, r_exp.data);
            chk("rresp", rresp, r_exp.resp);
            chk("rlast", rlast, r_exp.last);
            if (r_exp.last) begin
              last_r_cyc = cyc;
              chk_ar_next = 1;
            end
          end
        end
      end else begin
        r_stall = 0;
      end
    end
  end

  // Write-response monitor.
  bit chk_aw_next = 0;
  bexp_t b_exp;
  always @(negedge clk) begin
    if (rst) begin
      chk_aw_next = 0;
    end else begin
      if (chk_aw_next) begin
        chk("awready_after_b", awready, 1);
        chk_aw_next = 0;
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected: response bid=%0h accepted, required none", bid);
        end else begin
          b_exp = bq.pop_front();
          chk("bid", bid, b_exp.id);
          chk("bresp", bresp, b_exp.resp);
          chk_aw_next = 1;
        end
      end
    end
  end

  // Model: beat k of a burst lives at base+k in unbounded arithmetic.
  task automatic push_read_exp(input logic [ID_W-1:0] id, input int addr, input int len);
    for (int k = 0; k <= len; k++) begin
      rbeat_t b;
      int a;
      a = addr + k;
      b.id = id;
      if (a < DEPTH) begin
        b.data = ref_mem[a];
        b.resp = RESP_OKAY;
      end else begin
        b.data = '0;
        b.resp = RESP_SLVERR;
      end
      b.last = (k == len);
      rq.push_back(b);
    end
  endtask

  task automatic drive_read(input logic [ID_W-1:0] id, input int addr, input int len,
                            input bit chk_lat);
    int n;
    int t_ar;
    n = 0;
    arvalid = 1'b1;
    arid    = id;
    araddr  = ADDR_W'(addr);
    arlen   = LEN_W'(len);
    while (!arready && n < 200) begin step(); n++; end
    if (!arready) fail_timeout("ar_handshake");
    t_ar = cyc;
    step();
    arvalid = 1'b0;
    if (chk_lat) chk("r_first_latency", rvalid, 1);
    n = 0;
    while (rq.size() > 0 && n < 2000) begin step(); n++; end
    if (rq.size() > 0) begin
      fail_timeout("r_burst_done");
      rq.delete();
    end else if (chk_lat) begin
      chk("r_burst_cycles", last_r_cyc - t_ar, len + 1);
    end
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input int addr, input int len,
                         input bit chk_lat);
    push_read_exp(id, addr, len);
    drive_read(id, addr, len, chk_lat);
  endtask

  // Writes wdat[0..len]; lastmask bit k drives wlast on beat k.
  task automatic do_write(input logic [ID_W-1:0] id, input int addr, input int len,
                          input logic [15:0] lastmask, input bit gaps, input bit chk_lat);
    int n;
    int t_aw;
    int t_last;
    bit err;
    bexp_t be;
    err = 0;
    for (int k = 0; k <= len; k++) begin
      if (addr + k < DEPTH) ref_mem[addr + k] = wdat[k];
      else err = 1;
      if (lastmask[k] != (k == len)) err = 1;
    end
    be.id = id;
    be.resp = err ? RESP_SLVERR : RESP_OKAY;
    bq.push_back(be);
    n = 0;
    awvalid = 1'b1;
    awid    = id;
    awaddr  = ADDR_W'(addr);
    awlen   = LEN_W'(len);
    while (!awready && n < 200) begin step(); n++; end
    if (!awready) fail_timeout("aw_handshake");
    t_aw = cyc;
    step();
    awvalid = 1'b0;
    chk("wready_latency", wready, 1);
    t_last = 0;
    for (int k = 0; k <= len; k++) begin
      if (gaps) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      wvalid = 1'b1;
      wdata  = wdat[k];
      wlast  = lastmask[k];
      n = 0;
      while (!wready && n < 200) begin step(); n++; end
      if (!wready) fail_timeout("w_handshake");
      t_last = cyc;
      step();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    chk("b_latency", bvalid, 1);
    if (chk_lat) chk("w_burst_cycles", t_last - t_aw, len + 1);
    n = 0;
    while (bq.size() > 0 && n < 500) begin step(); n++; end
    if (bq.size() > 0) begin
      fail_timeout("b_done");
      bq.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arready"}, arready, 1);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rlast"}, rlast, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rresp"}, rresp, 0);
    chk({tag, "_rid"}, rid, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_bresp"}, bresp, 0);
    chk({tag, "_bid"}, bid, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    int addr;
    logic [15:0] mask;
    rst = 1'b1;
    arvalid = 0; arid = '0; araddr = '0; arlen = '0;
    awvalid = 0; awid = '0; awaddr = '0; awlen = '0;
    wvalid = 0; wdata = '0; wlast = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Give every implemented word a known value.
    for (int base = 0; base < DEPTH; base += 16) begin
      len = (DEPTH - 1 - base < 15) ? DEPTH - 1 - base : 15;
      for (int k = 0; k < 16; k++) wdat[k] = DATA_W'($urandom);
      do_write(ID_W'(base), base, len, 16'(1 << len), 0, 1);
    end

    // Basic write/read-back.
    for (int k = 0; k < 4; k++) wdat[k] = DATA_W'(8'hA1 + k);
    do_write(4'h5, 'h10, 3, 16'b1000, 0, 1);
    do_read(4'h3, 'h10, 3, 1);

    // Range boundary at DEPTH and past 2^ADDR_W.
    do_read(4'h7, 198, 3, 1);
    for (int k = 0; k < 4; k++) wdat[k] = DATA_W'($urandom);
    do_write(4'h2, 198, 3, 16'b1000, 0, 1);
    do_read(4'h8, 196, 3, 1);
    do_read(4'hA, 'hF8, 15, 1);

    // wlast early and missing.
    for (int k = 0; k < 4; k++) wdat[k] = DATA_W'($urandom);
    do_write(4'h4, 'h30, 2, 16'b010, 0, 1);
    for (int k = 0; k < 4; k++) wdat[k] = DATA_W'($urandom);
    do_write(4'hB, 'h40, 3, 16'b0000, 0, 1);
    do_read(4'hC, 'h30, 15, 1);

    // rready stalls mid-burst.
    rr_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_read(4'h9, 'h10, 3, 0);

    // Concurrent overlapping bursts: read sees the pre-write contents.
    for (int k = 0; k < 8; k++) wdat[k] = DATA_W'($urandom);
    push_read_exp(4'h1, 'h50, 7);
    fork
      drive_read(4'h1, 'h50, 7, 1);
      do_write(4'h6, 'h51, 7, 16'h0080, 0, 1);
    join
    do_read(4'h2, 'h50, 8, 1);

    // Reset in the middle of a 4-beat write.
    for (int k = 0; k < 4; k++) wdat[k] = DATA_W'($urandom);
    awvalid = 1'b1; awid = 4'h6; awaddr = 8'd40; awlen = 4'd3;
    step();
    awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wvalid = 1'b1; wdata = wdat[k]; wlast = 1'b0;
      step();
    end
    ref_mem[40] = wdat[0];
    ref_mem[41] = wdat[1];
    wvalid = 1'b1; wdata = wdat[2];
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    step();
    wvalid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("no_b_after_reset", bvalid, 0);
      step();
    end
    do_read(4'hD, 40, 3, 1);

    // Randomized traffic with back-pressure and write gaps.
    rr_rand = 1;
    br_rand = 1;
    for (int it = 0; it < 40; it++) begin
      addr = $urandom_range(0, 255);
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) begin
        do_read(ID_W'($urandom), addr, len, 0);
      end else begin
        for (int k = 0; k < 16; k++) wdat[k] = DATA_W'($urandom);
        mask = 16'(1 << len);
        if ($urandom_range(0, 3) == 0) mask = 16'($urandom_range(0, 65535));
        do_write(ID_W'($urandom), addr, len, mask, 1, 0);
      end
    end
    rr_rand = 0;
    br_rand = 0;
    do_read(4'hE, 0, 15, 1);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
